// File: rtl/serial_byte_capture_pkg.sv
// Shared types and widths for the serial byte capture front end.
package serial_byte_capture_pkg;

  localparam int BYTE_W = 8;
  localparam int CNT_W  = 3;

  typedef enum logic [1:0] {
    IDLE,
    DATA,
    PAR
  } cap_state_t;

endpackage

// File: rtl/serial_byte_capture.sv
// Deserializes a framed, qualified bit stream into bytes with optional even parity,
// emitting one-cycle enable, clear (aborted frame) and parity-error pulses.
module serial_byte_capture
  import serial_byte_capture_pkg::*;
#(
  parameter bit LSB_FIRST = 1'b1,
  parameter bit PARITY_EN = 1'b0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              frame,
  input  logic              sin_valid,
  input  logic              sin_bit,
  output logic [BYTE_W-1:0] d_out,
  output logic              en_out,
  output logic              clr_out,
  output logic              err
);

  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(BYTE_W - 1);

  cap_state_t        state, state_n;
  logic [CNT_W-1:0]  cnt, cnt_n;
  logic              armed;
  logic [BYTE_W-1:0] sr, sr_shift, load_byte;
  logic              shift, load;
  logic              en_n, clr_n, err_n;

  // armed stays low after reset until frame is seen low, so a frame that
  // straddles reset release is never captured half-way through
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      cnt   <= '0;
      armed <= 1'b0;
    end else begin
      state <= state_n;
      cnt   <= cnt_n;
      if (!frame) armed <= 1'b1;
    end
  end

  always_comb begin
    if (LSB_FIRST) sr_shift = {sin_bit, sr[BYTE_W-1:1]};
    else           sr_shift = {sr[BYTE_W-2:0], sin_bit};
  end

  always_comb begin
    state_n   = state;
    cnt_n     = cnt;
    shift     = 1'b0;
    load      = 1'b0;
    load_byte = sr_shift;
    en_n      = 1'b0;
    clr_n     = 1'b0;
    err_n     = 1'b0;
    case (state)
      IDLE: begin
        if (frame && armed) begin
          state_n = DATA;
          cnt_n   = '0;
          if (sin_valid) begin
            shift = 1'b1;
            cnt_n = CNT_W'(1);
          end
        end
      end
      DATA: begin
        if (!frame) begin
          state_n = IDLE;
          cnt_n   = '0;
          clr_n   = (cnt != '0);
        end else if (sin_valid) begin
          shift = 1'b1;
          if (cnt == LAST_BIT) begin
            cnt_n = '0;
            if (PARITY_EN) begin
              state_n = PAR;
            end else begin
              load = 1'b1;
              en_n = 1'b1;
            end
          end else begin
            cnt_n = cnt + CNT_W'(1);
          end
        end
      end
      PAR: begin
        load_byte = sr;
        if (!frame) begin
          state_n = IDLE;
          cnt_n   = '0;
          clr_n   = 1'b1;
        end else if (sin_valid) begin
          state_n = DATA;
          cnt_n   = '0;
          // even parity: data bits plus the parity bit must XOR to zero
          if (^{sr, sin_bit} == 1'b0) begin
            load = 1'b1;
            en_n = 1'b1;
          end else begin
            err_n = 1'b1;
          end
        end
      end
      default: begin
        state_n = IDLE;
        cnt_n   = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sr      <= '0;
      d_out   <= '0;
      en_out  <= 1'b0;
      clr_out <= 1'b0;
      err     <= 1'b0;
    end else begin
      if (shift) sr <= sr_shift;
      if (load) d_out <= load_byte;
      en_out  <= en_n;
      clr_out <= clr_n;
      err     <= err_n;
    end
  end

endmodule

// File: tb/tb_serial_byte_capture.sv
// Scoreboard bench for serial_byte_capture: three instances cover LSB-first,
// MSB-first and parity builds; expected pulses are queued when stimulus is driven.
module tb_serial_byte_capture;

  localparam int N_INST = 3;
  localparam int K_EN   = 1;
  localparam int K_CLR  = 2;
  localparam int K_ERR  = 4;

  typedef struct {
    int         idx;
    int         kind;
    logic [7:0] data;
    int         cyc;
  } exp_t;

  logic       clk;
  logic       rst;
  logic       frame_v [N_INST];
  logic       valid_v [N_INST];
  logic       bit_v   [N_INST];
  logic [7:0] d_v     [N_INST];
  logic       en_v    [N_INST];
  logic       clr_v   [N_INST];
  logic       err_v   [N_INST];

  exp_t       sb [$];
  logic [7:0] cur_d [N_INST];
  int         cyc;
  int         checks;
  int         errors;
  exp_t       e;
  logic [2:0] pulse;

  serial_byte_capture #(.LSB_FIRST(1'b1), .PARITY_EN(1'b0)) dut_lsb (
    .clk(clk), .rst(rst), .frame(frame_v[0]), .sin_valid(valid_v[0]), .sin_bit(bit_v[0]),
    .d_out(d_v[0]), .en_out(en_v[0]), .clr_out(clr_v[0]), .err(err_v[0])
  );

  serial_byte_capture #(.LSB_FIRST(1'b0), .PARITY_EN(1'b0)) dut_msb (
    .clk(clk), .rst(rst), .frame(frame_v[1]), .sin_valid(valid_v[1]), .sin_bit(bit_v[1]),
    .d_out(d_v[1]), .en_out(en_v[1]), .clr_out(clr_v[1]), .err(err_v[1])
  );

  serial_byte_capture #(.LSB_FIRST(1'b1), .PARITY_EN(1'b1)) dut_par (
    .clk(clk), .rst(rst), .frame(frame_v[2]), .sin_valid(valid_v[2]), .sin_bit(bit_v[2]),
    .d_out(d_v[2]), .en_out(en_v[2]), .clr_out(clr_v[2]), .err(err_v[2])
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", tag, actual, expected, cyc);
    end
  endtask

  task automatic applyStimulus(input int i, input bit f, input bit v, input bit b);
    @(posedge clk);
    #1;
    frame_v[i] = f;
    valid_v[i] = v;
    bit_v[i]   = b;
  endtask

  // inputs are sampled on the next rising edge, so the pulse shows one cycle later
  task automatic pushExp(input int i, input int kind, input logic [7:0] data);
    exp_t x;
    x.idx  = i;
    x.kind = kind;
    x.data = data;
    x.cyc  = cyc + 1;
    sb.push_back(x);
  endtask

  task automatic sendByte(input int i, input logic [7:0] data, input bit lsbFirst,
                          input bit stall, input bit push);
    for (int k = 0; k < 8; k++) begin
      applyStimulus(i, 1'b1, 1'b1, lsbFirst ? data[k] : data[7-k]);
      if (k == 7 && push) pushExp(i, K_EN, data);
      if (stall) applyStimulus(i, 1'b1, 1'b0, 1'($urandom));
    end
  endtask

  task automatic checkResetState(input int i);
    @(negedge clk);
    checkOutput("reset_d_out", d_v[i], 8'h00);
    checkOutput("reset_en_out", en_v[i], 1'b0);
    checkOutput("reset_clr_out", clr_v[i], 1'b0);
    checkOutput("reset_err", err_v[i], 1'b0);
  endtask

  // every pulse must match the head of the queue; between pulses d_out must hold
  always @(negedge clk) begin
    if (rst) begin
      for (int i = 0; i < N_INST; i++) cur_d[i] = 8'h00;
    end else begin
      for (int i = 0; i < N_INST; i++) begin
        pulse = {err_v[i], clr_v[i], en_v[i]};
        if (pulse != 3'b000) begin
          if (sb.size() == 0) begin
            checkOutput("unexpected_pulse", pulse, 3'b000);
          end else begin
            e = sb.pop_front();
            checkOutput("pulse_inst", i, e.idx);
            checkOutput("pulse_kind", pulse, e.kind);
            checkOutput("pulse_cycle", cyc, e.cyc);
            if (e.kind == K_EN) cur_d[i] = e.data;
            checkOutput("pulse_d_out", d_v[i], cur_d[i]);
          end
        end else begin
          checkOutput("hold_d_out", d_v[i], cur_d[i]);
        end
      end
      if (sb.size() > 0 && sb[0].cyc < cyc) begin
        e = sb.pop_front();
        checkOutput("missed_pulse_cycle", cyc, e.cyc);
      end
    end
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    checks = 0;
    errors = 0;
    rst    = 1'b1;
    for (int i = 0; i < N_INST; i++) begin
      frame_v[i] = 1'b0;
      valid_v[i] = 1'b0;
      bit_v[i]   = 1'b0;
    end
    repeat (3) @(posedge clk);
    checkResetState(0);
    checkResetState(2);
    @(posedge clk);
    #1 rst = 1'b0;
    applyStimulus(0, 1'b0, 1'b0, 1'b0);

    $display("[TB] LSB-first single byte");
    sendByte(0, 8'hA5, 1'b1, 1'b0, 1'b1);
    applyStimulus(0, 1'b0, 1'b0, 1'b0);

    $display("[TB] MSB-first back-to-back bytes");
    applyStimulus(1, 1'b0, 1'b0, 1'b0);
    sendByte(1, 8'hA5, 1'b0, 1'b0, 1'b1);
    sendByte(1, 8'h3C, 1'b0, 1'b0, 1'b1);
    sendByte(1, 8'h81, 1'b0, 1'b0, 1'b1);
    applyStimulus(1, 1'b0, 1'b0, 1'b0);

    $display("[TB] parity build");
    applyStimulus(2, 1'b0, 1'b0, 1'b0);
    sendByte(2, 8'hA5, 1'b1, 1'b0, 1'b0);
    applyStimulus(2, 1'b1, 1'b1, 1'b0);
    pushExp(2, K_EN, 8'hA5);
    sendByte(2, 8'h01, 1'b1, 1'b0, 1'b0);
    applyStimulus(2, 1'b1, 1'b1, 1'b0);
    pushExp(2, K_ERR, 8'h00);
    sendByte(2, 8'h07, 1'b1, 1'b1, 1'b0);
    applyStimulus(2, 1'b1, 1'b1, 1'b1);
    pushExp(2, K_EN, 8'h07);
    sendByte(2, 8'h3C, 1'b1, 1'b0, 1'b0);
    applyStimulus(2, 1'b0, 1'b1, 1'b0);
    pushExp(2, K_CLR, 8'h00);
    applyStimulus(2, 1'b0, 1'b0, 1'b0);

    $display("[TB] abort mid-byte then full byte");
    for (int k = 0; k < 5; k++) applyStimulus(0, 1'b1, 1'b1, 1'(k));
    applyStimulus(0, 1'b0, 1'b1, 1'b1);
    pushExp(0, K_CLR, 8'h00);
    applyStimulus(0, 1'b0, 1'b0, 1'b0);
    sendByte(0, 8'hFF, 1'b1, 1'b0, 1'b1);
    applyStimulus(0, 1'b0, 1'b0, 1'b0);

    $display("[TB] stalls inside a byte");
    sendByte(0, 8'hA5, 1'b1, 1'b1, 1'b1);
    applyStimulus(0, 1'b0, 1'b0, 1'b0);

    $display("[TB] reset mid-frame");
    for (int k = 0; k < 4; k++) applyStimulus(0, 1'b1, 1'b1, 1'b1);
    applyStimulus(0, 1'b1, 1'b0, 1'b0);
    rst = 1'b1;
    @(posedge clk);
    checkResetState(0);
    @(posedge clk);
    #1 rst = 1'b0;
    for (int k = 0; k < 12; k++) applyStimulus(0, 1'b1, 1'b1, 1'(k));
    applyStimulus(0, 1'b0, 1'b0, 1'b0);
    sendByte(0, 8'h5A, 1'b1, 1'b0, 1'b1);
    applyStimulus(0, 1'b0, 1'b0, 1'b0);

    repeat (4) @(posedge clk);
    @(negedge clk);
    checkOutput("scoreboard_empty", sb.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/serial_byte_capture.md
# serial_byte_capture

Upstream feeder for the byte-wide enable/reset register stage. It deserializes a framed, qualified serial bit stream into 8-bit bytes and drives a one-cycle enable pulse with the assembled byte. It also drives a one-cycle clear pulse when a frame is aborted mid-byte. Optional even parity per byte is checked before the enable is issued.

## Interface
- LSB_FIRST, 1, 1: first received bit lands in d_out[0]; 0: first bit lands in d_out[7]
- PARITY_EN, 0, 1: a 9th bit (even parity over data+parity) follows each byte
- clk  input  1  clock, rising edge
- rst  input  1  reset, synchronous, active-high
- frame  input  1  high for the whole duration of a frame; low = no frame
- sin_valid  input  1  sin_bit is qualified this cycle
- sin_bit  input  1  serial data bit
- d_out  output  8  last completed byte; holds between emissions
- en_out  output  1  one-cycle pulse: d_out carries a new valid byte
- clr_out  output  1  one-cycle pulse: frame dropped with a partial byte pending
- err  output  1  one-cycle pulse: parity mismatch; byte discarded

## Operation
- States: IDLE, DATA, PAR. A 3-bit counter cnt counts data bits; an 8-bit shift register sr holds them.
- IDLE: when frame=1, go to DATA with cnt=0. If sin_valid=1 in the same cycle, accept that bit as bit 0 and set cnt=1.
- DATA: each cycle with frame=1 and sin_valid=1 shifts sin_bit into sr per LSB_FIRST and increments cnt.
  - On the 8th accepted bit, go to PAR if PARITY_EN=1.
  - Otherwise, load d_out with the completed byte and pulse en_out. Stay in DATA with cnt=0 if frame is still 1 in that cycle; else go to IDLE.
- PAR: the next accepted bit p is checked.
  - If XOR of data and p is 0, load d_out and pulse en_out.
  - Else pulse err; d_out is unchanged.
  - Next state is DATA (cnt=0) if frame=1, else IDLE.
- Abort: frame=0 while in DATA with cnt>0, or while in PAR, means:
  - pulse clr_out, go to IDLE, clear cnt;
  - d_out is unchanged;
  - a sin_valid bit in the same cycle is ignored.
- frame=0 in DATA with cnt=0 goes to IDLE silently, with no clr_out.
- sin_valid=0 cycles inside a frame are stalls: no state change.
- en_out, clr_out and err are mutually exclusive in any cycle.
- Reset: d_out=8'h00, en_out=0, clr_out=0, err=0, sr=0, cnt=0, state IDLE.
  - Reset mid-frame discards the partial byte with no clr_out.
  - After reset deasserts, frame must go low and then high again before capture resumes.
  - A frame already high at reset release is ignored until it drops.

## Timing
- All outputs are registered; there is no combinational input-to-output path.
- en_out/err are high the cycle after the clock edge sampling the last data bit (PARITY_EN=0) or the parity bit (PARITY_EN=1). d_out updates on the same edge as en_out.
- clr_out is high the cycle after the edge sampling frame=0.
- Back-to-back bytes: with sin_valid held high, en_out pulses every 8 cycles (9 with parity); no idle gap is required.
- Minimum latency from the first bit sampled to en_out: 8 cycles (9 with parity).

## Structure
- Package serial_byte_capture_pkg holds:
  - state enum cap_state_t {IDLE, DATA, PAR};
  - localparam BYTE_W=8;
  - localparam CNT_W=3.
- Single module, no sub-modules. The shift/parity datapath and the FSM live in separate always_ff blocks with a combinational next-state block.

## Test plan
- LSB_FIRST=1, PARITY_EN=0: frame=1, bits 1,0,1,0,0,1,0,1 on consecutive cycles -> single en_out pulse, d_out=8'hA5.
- LSB_FIRST=0: same bit sequence -> d_out=8'hA5 with reversed bit order, i.e. 8'hA5 appears as 8'b10100101 MSB-first. Two bytes back-to-back (0xA5, 0x3C) -> en_out pulses 8 cycles apart, d_out holds each value until the next pulse.
- PARITY_EN=1: 0xA5 followed by p=0 -> en_out, d_out=8'hA5. 0x01 followed by p=0 -> err pulse, d_out stays 8'hA5.
- Abort: 5 bits accepted, then frame=0 with sin_valid=1 -> clr_out pulse, d_out unchanged. A new full byte 0xFF then produces d_out=8'hFF.
- Stalls: sin_valid toggled 1/0 across 0xA5 -> en_out only after the 8th valid bit, d_out=8'hA5.
- Reset after 4 bits accepted -> all outputs 0. Frame held high across reset produces no capture; after a frame low-then-high, a full 0x5A gives d_out=8'h5A.
